// File: rtl/interleaver_ctrl_if.sv
// Bundle of every signal between the interleaver controller and the outside
// world, apart from clock and reset.
//   master : the controller side (drives RAM strobes, addresses, framing)
//   slave  : the environment side (drives mode, in_valid, out_ready)
// Signals:
//   mode, in_valid, in_ready          - input symbol handshake + frame mode
//   wr_en, wr_bank, wr_addr           - RAM write port control
//   rd_en, rd_bank, rd_addr           - RAM read port control
//   out_valid, out_ready              - output handshake, aligned to RAM data
//   out_sof, out_eof                  - first/last symbol of an output frame
//   frame_cnt                         - frames fully delivered downstream
interface interleaver_ctrl_if #(
  parameter int AW = 4
);
  logic          mode;
  logic          in_valid;
  logic          in_ready;
  logic          wr_en;
  logic          wr_bank;
  logic [AW-1:0] wr_addr;
  logic          rd_en;
  logic          rd_bank;
  logic [AW-1:0] rd_addr;
  logic          out_valid;
  logic          out_ready;
  logic          out_sof;
  logic          out_eof;
  logic [7:0]    frame_cnt;

  modport master (
    input  mode, in_valid, out_ready,
    output in_ready, wr_en, wr_bank, wr_addr,
    output rd_en, rd_bank, rd_addr,
    output out_valid, out_sof, out_eof, frame_cnt
  );

  modport slave (
    output mode, in_valid, out_ready,
    input  in_ready, wr_en, wr_bank, wr_addr,
    input  rd_en, rd_bank, rd_addr,
    input  out_valid, out_sof, out_eof, frame_cnt
  );
endinterface

// File: rtl/interleaver_ctrl.sv
// Sequencing controller for a ping-pong block interleaver/deinterleaver.
// Two RAM banks of ROWS*COLS symbols are written row-major and read back in
// a permuted order (column-major for interleave, the inverse permutation for
// deinterleave). The controller carries no data: it only generates RAM
// strobes/addresses and output framing aligned to a RAM with 1-cycle read
// latency whose output register holds while rd_en is low.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset, discards all buffered frames
//   bus  - interleaver_ctrl_if master modport (handshakes, RAM control,
//          framing, frame counter)
module interleaver_ctrl #(
  parameter int ROWS = 4,
  parameter int COLS = 4,
  parameter int AW   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  interleaver_ctrl_if.master   bus
);

  localparam int N = ROWS * COLS;
  localparam logic [AW-1:0] LAST = AW'(N - 1);

  logic          wr_bank;
  logic          rd_bank;
  logic [AW-1:0] wr_cnt;
  logic [AW-1:0] rd_cnt;
  logic [1:0]    full;
  logic [1:0]    full_next;
  logic [1:0]    mode_r;
  logic          out_valid_q;
  logic          out_sof_q;
  logic          out_eof_q;
  logic [7:0]    frame_cnt_q;
  logic          in_ready;
  logic          wr_en;
  logic          rd_en;
  logic          wr_last;
  logic          rd_last;
  logic [AW-1:0] rd_addr_c;

  assign in_ready = !full[wr_bank];
  assign wr_en    = bus.in_valid & in_ready;
  // A read may be issued whenever the output register is empty or is being
  // drained this cycle, so a stalled beat is never overwritten.
  assign rd_en    = full[rd_bank] & (!out_valid_q | bus.out_ready);
  assign wr_last  = (wr_cnt == LAST);
  assign rd_last  = (rd_cnt == LAST);

  // Read permutation. Each bank remembers the mode its frame was written
  // with, so a mode change only affects frames started after it.
  always_comb begin
    int k;
    k = int'(rd_cnt);
    rd_addr_c = '0;
    if (!mode_r[rd_bank])
      rd_addr_c = AW'((k % ROWS) * COLS + k / ROWS);
    else
      rd_addr_c = AW'((k % COLS) * ROWS + k / COLS);
  end

  // Bank occupancy. Set and clear can never target the same bank in one
  // cycle: writing needs the bank empty, reading needs it full.
  always_comb begin
    full_next = full;
    if (wr_en && wr_last)
      full_next[wr_bank] = 1'b1;
    if (rd_en && rd_last)
      full_next[rd_bank] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank     <= 1'b0;
      rd_bank     <= 1'b0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      full        <= '0;
      mode_r      <= '0;
      out_valid_q <= 1'b0;
      out_sof_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      full <= full_next;

      if (wr_en) begin
        if (wr_cnt == '0)
          mode_r[wr_bank] <= bus.mode;
        if (wr_last) begin
          wr_cnt  <= '0;
          wr_bank <= ~wr_bank;
        end else begin
          wr_cnt <= wr_cnt + AW'(1);
        end
      end

      if (rd_en) begin
        if (rd_last) begin
          rd_cnt  <= '0;
          rd_bank <= ~rd_bank;
        end else begin
          rd_cnt <= rd_cnt + AW'(1);
        end
      end

      // Framing registers track the RAM read-data register one cycle behind
      // the read strobe, and hold with it under backpressure.
      if (rd_en) begin
        out_valid_q <= 1'b1;
        out_sof_q   <= (rd_cnt == '0);
        out_eof_q   <= rd_last;
      end else if (bus.out_ready) begin
        out_valid_q <= 1'b0;
        out_sof_q   <= 1'b0;
        out_eof_q   <= 1'b0;
      end

      if (out_valid_q && bus.out_ready && out_eof_q)
        frame_cnt_q <= frame_cnt_q + 8'd1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.wr_en     = wr_en;
  assign bus.wr_bank   = wr_bank;
  assign bus.wr_addr   = wr_cnt;
  assign bus.rd_en     = rd_en;
  assign bus.rd_bank   = rd_bank;
  assign bus.rd_addr   = rd_addr_c;
  assign bus.out_valid = out_valid_q;
  assign bus.out_sof   = out_sof_q;
  assign bus.out_eof   = out_eof_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
